// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and default widths for the data-RAM port arbiter
// and the RAM wrapper it drives.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 16;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way request picker with a registered fairness pointer.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (m0 always
// wins a tie); in that build the pointer register is not present.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner_m0,
  output logic [1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clock, reset, update, owner_m0};

  // m0 wins whenever it asks; m1 only when m0 is quiet
  always_comb begin
    grant = 2'b00;
    if (req[0])
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end

`else

  // prio_m1 set means m1 wins the next tie (m0 was served last)
  logic prio_m1;

  // pointer moves to the requester that was not just served
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      prio_m1 <= 1'b0;
    else if (update)
      prio_m1 <= owner_m0;
  end

  // a lone requester always wins; a tie goes to the favoured side
  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = prio_m1 ? 2'b10 : 2'b01;
  end

`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one data-RAM port between the processor data path
// (m0) and the loader/display reader (m1). Single-word req/ack transactions,
// read latency absorbed by a down-counter, read data returned on a shared bus.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (see rr_arbiter2).
//
// state | meaning
// IDLE  | wait for a request, latch winner's address/data/we
// ISSUE | RAM port driven; wren high for writes this cycle only
// WAIT  | count down the RAM read latency, capture ram_q on the last cycle
// RESP  | ack the owner, advance the fairness pointer, release the port
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int RD_LAT = RAM_RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [1:0]        gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ram_arb_state_t   state, state_nxt;
  logic [1:0]       arb_grant;
  logic             arb_update;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      ({m1_req, m0_req}),
    .update   (arb_update),
    .owner_m0 (gnt[0]),
    .grant    (arb_grant)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next state and pointer-update strobe
  always_comb begin
    state_nxt  = state;
    arb_update = 1'b0;
    case (state)
      IDLE:  if (|arb_grant) state_nxt = ISSUE;
      ISSUE: state_nxt = we_q ? RESP : WAIT;
      WAIT:  if (cnt == CNT_ONE) state_nxt = RESP;
      RESP: begin
        state_nxt  = IDLE;
        arb_update = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // port latches, latency counter and read-data capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt         <= 2'b00;
      ram_address <= '0;
      ram_data    <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            gnt         <= arb_grant;
            ram_address <= arb_grant[1] ? m1_addr  : m0_addr;
            ram_data    <= arb_grant[1] ? m1_wdata : m0_wdata;
            we_q        <= arb_grant[1] ? m1_we    : m0_we;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            rdata <= ram_q;
        end
        RESP: gnt <= 2'b00;
        default: gnt <= 2'b00;
      endcase
    end
  end

  // wren only in ISSUE; acks only in RESP, to the owner
  always_comb begin
    ram_wren = (state == ISSUE) && we_q;
    m0_ack   = (state == RESP) && gnt[0];
    m1_ack   = (state == RESP) && gnt[1];
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: transaction-level model predicts each grant (winner,
// cycle numbers, read data); a negedge monitor compares the DUT against the
// queued expectations every cycle.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  parameter int RD_LAT = 1;
  localparam int TMO = 400;

  logic              clock, reset;
  logic              m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [ADDR_W-1:0] m0_addr, m1_addr, ram_address;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, rdata, ram_data, ram_q;
  logic [1:0]        gnt;
  logic              ram_wren;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .gnt(gnt), .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] preload(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // RAM environment: synchronous write, RD_LAT-stage registered read
  logic [DATA_W-1:0] ram_mem [int];
  logic [DATA_W-1:0] ram_pipe [RD_LAT];
  logic [DATA_W-1:0] ram_rd;
  assign ram_q = ram_pipe[RD_LAT-1];

  always @(posedge clock) begin
    ram_rd = ram_mem.exists(int'(ram_address)) ? ram_mem[int'(ram_address)] : preload(int'(ram_address));
    if (ram_wren) ram_mem[int'(ram_address)] = ram_data;
    for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
    ram_pipe[0] <= ram_rd;
  end

  // reference model: one transaction at a time, timing from cycle arithmetic
  typedef struct {
    int          who;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          grant_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_rd;
  bit          rr_m1;
  int          free_cyc;
  int          mw;
  exp_t        me;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sb.delete();
      rr_m1    = 1'b0;
      last_rd  = '0;
      free_cyc = 0;
    end else begin
      if (cyc >= free_cyc && (m0_req || m1_req)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        mw = m0_req ? 0 : 1;
`else
        if (m0_req && m1_req) mw = rr_m1 ? 1 : 0;
        else                  mw = m1_req ? 1 : 0;
`endif
        rr_m1        = (mw == 0);
        me.who       = mw;
        me.we        = mw ? m1_we : m0_we;
        me.addr      = mw ? m1_addr : m0_addr;
        me.wdata     = mw ? m1_wdata : m0_wdata;
        me.grant_cyc = cyc;
        if (me.we) begin
          model_mem[int'(me.addr)] = me.wdata;
          me.ack_cyc = cyc + 2;
        end else begin
          last_rd = model_mem.exists(int'(me.addr)) ? model_mem[int'(me.addr)] : preload(int'(me.addr));
          me.ack_cyc = cyc + 2 + RD_LAT;
        end
        me.rdata = last_rd;
        sb.push_back(me);
        free_cyc = me.ack_cyc + 1;
      end
      cyc = cyc + 1;
    end
  end

  // monitor: per-cycle check of gnt/wren/port and ack/rdata against the model
  logic [1:0] exp_gnt;
  logic       exp_wren;
  exp_t       fe;

  always @(negedge clock) begin
    if (!reset) begin
      exp_gnt  = 2'b00;
      exp_wren = 1'b0;
      if (sb.size() > 0) begin
        fe = sb[0];
        if (cyc > fe.grant_cyc && cyc <= fe.ack_cyc) exp_gnt = fe.who ? 2'b10 : 2'b01;
        if (cyc == fe.grant_cyc + 1) begin
          exp_wren = fe.we;
          chk("ram_address", 32'(ram_address), 32'(fe.addr));
          if (fe.we) chk("ram_data", ram_data, fe.wdata);
        end
      end
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("ram_wren", 32'(ram_wren), 32'(exp_wren));
      if (sb.size() > 0 && cyc == sb[0].ack_cyc) begin
        chk("ack", 32'({m1_ack, m0_ack}), sb[0].who ? 32'd2 : 32'd1);
        chk("rdata", rdata, sb[0].rdata);
        void'(sb.pop_front());
      end else begin
        chk("stray_ack", 32'({m1_ack, m0_ack}), 32'd0);
      end
    end
  end

  task automatic set_req(int who, logic r, logic we, logic [15:0] a, logic [31:0] d);
    if (who == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else          begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  // called at posedge+1; returns at posedge+1 with req dropped
  task automatic do_txn(int who, logic we, logic [15:0] a, logic [31:0] d, bit drop_early);
    bit got = 0;
    set_req(who, 1'b1, we, a, d);
    for (int n = 0; n < TMO; n++) begin
      @(negedge clock);
      if (drop_early && n == 1) set_req(who, 1'b0, we, a, d);
      if ((who == 0 && m0_ack) || (who == 1 && m1_ack)) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: m%0d got no ack, expected one within %0d cycles", who, TMO);
    end
    @(posedge clock);
    #1;
    set_req(who, 1'b0, we, a, d);
  endtask

  task automatic rand_stream(int who, int count);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #0;
      do_txn(who, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 7)),
             $urandom, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_address", 32'(ram_address), 32'd0);
    chk("rst_data", ram_data, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // single write then read
    do_txn(0, 1'b1, 16'd653, 32'h1234_5678, 1'b0);
    do_txn(0, 1'b0, 16'd653, 32'h0, 1'b0);

    // tie: both hold reads continuously
    fork
      for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 16'd1, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) do_txn(1, 1'b0, 16'd2, 32'h0, 1'b0);
    join

    // read-after-write across requesters
    fork
      do_txn(1, 1'b1, 16'd7, 32'hCAFE_F00D, 1'b0);
      do_txn(0, 1'b0, 16'd7, 32'h0, 1'b0);
    join
    do_txn(1, 1'b0, 16'd7, 32'h0, 1'b0);

    // early req drop still completes; top address boundary
    do_txn(1, 1'b1, 16'd100, 32'h0BAD_0BAD, 1'b1);
    do_txn(1, 1'b0, 16'd100, 32'h0, 1'b0);
    do_txn(0, 1'b1, 16'hFFFF, 32'h5555_AAAA, 1'b0);
    do_txn(1, 1'b0, 16'hFFFF, 32'h0, 1'b0);
    do_txn(0, 1'b0, 16'h0000, 32'h0, 1'b0);

    // reset during WAIT of a read
    set_req(0, 1'b1, 1'b0, 16'd9, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    chk("midrst_wren", 32'(ram_wren), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    do_txn(0, 1'b0, 16'd5, 32'h0, 1'b0);

    // randomized traffic from both requesters
    fork
      rand_stream(0, 30);
      rand_stream(1, 30);
    join

    for (int n = 0; n < 50 && sb.size() > 0; n++) @(posedge clock);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected transactions left, expected 0", sb.size());
    end
    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
